spram_req_ctrl: RTL and testbench

Valid/ready request front-end for the single-port 64-bit byte-enable SRAM wrapper, with `ADDR_WIDTH` address bits and 1 or 2 cycles of read latency. It sits directly upstream of the SRAM macro wrapper and drives its `CSel`/`WrEn`/`BEn`/`WrData`/`Addr` pins. It captures the fixed-latency read data into a credit-protected response FIFO, so a consumer applying backpressure never loses read data. Writes are fire-and-forget.

---
 rtl/spram_pkg.sv | 20 ++
 rtl/spram_rsp_fifo.sv | 62 ++++++
 rtl/spram_req_ctrl.sv | 108 ++++++++++
 tb/tb_spram_req_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared widths, request struct and latency helper for the single-port SRAM
// request front-end and its response FIFO.
package spram_pkg;

    localparam int DATA_W     = 64;
    localparam int BE_W       = 8;
    localparam int ADDR_MAX_W = 32;

    typedef struct packed {
        logic                  write;
        logic [BE_W-1:0]       ben;
        logic [ADDR_MAX_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
    } spram_req_t;

    function automatic int spramRdLat(input int outRegs);
        return 1 + outRegs;
    endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Response FIFO for captured read data. The head entry is read straight from
// the storage registers, so the output holds steady until it is popped.
module spram_rsp_fifo
    import spram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q;
    logic [PW-1:0]     rdPtr_q;
    logic [CW-1:0]     cnt_q;
    logic              pushEn;
    logic              popEn;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rdPtr_q];

    // A pop frees the slot in the same cycle, so a full FIFO may push and pop together.
    assign popEn  = pop_i & ~empty_o;
    assign pushEn = push_i & (~full_o | popEn);

    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= nextPtr(wrPtr_q);
            end
            if (popEn) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            cnt_q <= cnt_q + CW'(pushEn) - CW'(popEn);
        end
    end

endmodule

// File: rtl/spram_req_ctrl.sv
// Valid/ready front-end for the single-port byte-enable SRAM wrapper. Reads are
// credit-limited so the fixed-latency read data always has a FIFO slot waiting.
module spram_req_ctrl
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REGS   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrite_SI,
    input  logic [BE_W-1:0]       ReqBEn_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_W-1:0]     ReqWrData_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [DATA_W-1:0]     RspData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [BE_W-1:0]       RamBEn_SO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    output logic [DATA_W-1:0]     RamWrData_DO,
    input  logic [DATA_W-1:0]     RamRdData_DI,
    output logic                  Busy_SO
);

    localparam int RD_LAT = spramRdLat(OUT_REGS);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    spram_req_t        req;
    logic [CW-1:0]     cred_q;
    logic [CW-1:0]     cred_d;
    logic [RD_LAT-1:0] rdVld_q;
    logic [RD_LAT-1:0] rdVld_d;
    logic              acc;
    logic              rdAcc;
    logic              pop;
    logic              push;
    logic              fifoFull;
    logic              fifoEmpty;

    always_comb begin
        req.write = ReqWrite_SI;
        req.ben   = ReqBEn_SI;
        req.addr  = ADDR_MAX_W'(ReqAddr_DI);
        req.wdata = ReqWrData_DI;
    end

    // During reset the credit count is treated as zero, and nothing reaches the RAM.
    assign ReqReady_SO = req.write | Rst_RI | (cred_q < CW'(FIFO_DEPTH));
    assign acc         = ReqValid_SI & ReqReady_SO & ~Rst_RI;
    assign rdAcc       = acc & ~req.write;

    assign RamCSel_SO   = acc;
    assign RamWrEn_SO   = acc & req.write;
    assign RamBEn_SO    = req.ben;
    assign RamAddr_DO   = ADDR_WIDTH'(req.addr);
    assign RamWrData_DO = req.wdata;

    assign pop     = RspValid_SO & RspReady_SI;
    assign push    = rdVld_q[RD_LAT-1];
    assign Busy_SO = (cred_q != '0);

    always_comb begin
        cred_d     = cred_q + CW'(rdAcc) - CW'(pop);
        rdVld_d    = rdVld_q << 1;
        rdVld_d[0] = rdAcc;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            cred_q  <= '0;
            rdVld_q <= '0;
        end else begin
            cred_q  <= cred_d;
            rdVld_q <= rdVld_d;
        end
    end

    spram_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rspFifo (
        .clk_i   (Clk_CI),
        .rst_i   (Rst_RI),
        .push_i  (push),
        .data_i  (RamRdData_DI),
        .pop_i   (pop),
        .data_o  (RspData_DO),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign RspValid_SO = ~fifoEmpty;

`ifndef SYNTHESIS
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RI) begin
            assert (FIFO_DEPTH >= 1 && FIFO_DEPTH <= 16);
            assert (!(push && fifoFull));
            assert (cred_q <= CW'(FIFO_DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl: directed scenarios with literal
// expectations plus a randomized phase checked against a request-level model.
module tb_spram_req_ctrl;

   localparam int ADDR_WIDTH = 10;
   localparam int OUT_REGS   = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int RD_LAT     = 1 + OUT_REGS;
   localparam int MEM_WORDS  = 1 << ADDR_WIDTH;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  preload = 1'b1;
   logic                  modelLive = 1'b0;
   logic                  reqValid = 1'b0;
   logic                  reqReady;
   logic                  reqWrite = 1'b0;
   logic [7:0]            reqBEn = 8'h00;
   logic [ADDR_WIDTH-1:0] reqAddr = '0;
   logic [63:0]           reqWrData = '0;
   logic                  rspValid;
   logic                  rspReady = 1'b1;
   logic [63:0]           rspData;
   logic                  ramCSel;
   logic                  ramWrEn;
   logic [7:0]            ramBEn;
   logic [ADDR_WIDTH-1:0] ramAddr;
   logic [63:0]           ramWrData;
   logic [63:0]           ramRdData;
   logic                  busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          readyAt;
      logic [63:0] data;
   } rsp_t;

   rsp_t        expQ[$];
   logic [63:0] refMem [MEM_WORDS];
   logic [63:0] ramMem [MEM_WORDS];
   logic [63:0] ramStage0 = '0;
   logic [63:0] ramStage1 = '0;

   spram_req_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .OUT_REGS   (OUT_REGS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .Clk_CI       (clock),
      .Rst_RI       (reset),
      .ReqValid_SI  (reqValid),
      .ReqReady_SO  (reqReady),
      .ReqWrite_SI  (reqWrite),
      .ReqBEn_SI    (reqBEn),
      .ReqAddr_DI   (reqAddr),
      .ReqWrData_DI (reqWrData),
      .RspValid_SO  (rspValid),
      .RspReady_SI  (rspReady),
      .RspData_DO   (rspData),
      .RamCSel_SO   (ramCSel),
      .RamWrEn_SO   (ramWrEn),
      .RamBEn_SO    (ramBEn),
      .RamAddr_DO   (ramAddr),
      .RamWrData_DO (ramWrData),
      .RamRdData_DI (ramRdData),
      .Busy_SO      (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   function automatic logic [63:0] initWord(input int i);
      if (i == 5) return 64'hDEADBEEF_CAFEF00D;
      return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'h5A5A5A5A};
   endfunction

   // Environment: the SRAM macro wrapper with RD_LAT cycles of read latency.
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < MEM_WORDS; i++) ramMem[i] <= initWord(i);
      end else if (ramCSel) begin
         if (ramWrEn) begin
            for (int b = 0; b < 8; b++)
               if (ramBEn[b]) ramMem[ramAddr][8*b +: 8] <= ramWrData[8*b +: 8];
         end else begin
            ramStage0 <= ramMem[ramAddr];
         end
      end
      ramStage1 <= ramStage0;
   end

   assign ramRdData = (OUT_REGS != 0) ? ramStage1 : ramStage0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic w, input logic [7:0] be,
                                input logic [ADDR_WIDTH-1:0] a, input logic [63:0] d, input logic rr);
      @(posedge clock);
      #1;
      reqValid  = v;
      reqWrite  = w;
      reqBEn    = be;
      reqAddr   = a;
      reqWrData = d;
      rspReady  = rr;
   endtask

   task automatic idleCycle(input logic rr);
      applyStimulus(1'b0, 1'b0, 8'h00, '0, 64'd0, rr);
   endtask

   // Waits a bounded number of cycles for the next response, consuming it.
   task automatic waitResponse(output int lat, output logic [63:0] data);
      lat  = -1;
      data = '0;
      for (int k = 1; k <= 10; k++) begin
         idleCycle(1'b1);
         #1;
         if (rspValid && lat < 0) begin
            lat  = k;
            data = rspData;
         end
      end
   endtask

   // Request-level model: reads owe their data in issue order, visible
   // RD_LAT+1 cycles after acceptance; outstanding reads never exceed FIFO_DEPTH.
   logic expReady, expAcc, expValid;
   rsp_t newRsp;

   always @(negedge clock) begin
      if (modelLive) begin
         expReady = reqWrite | reset | (expQ.size() < FIFO_DEPTH);
         expAcc   = reqValid & expReady & ~reset;
         expValid = (expQ.size() != 0) && (expQ[0].readyAt <= cyc);
         checkOutput("ReqReady", reqReady, expReady);
         checkOutput("RamCSel", ramCSel, expAcc);
         checkOutput("RamWrEn", ramWrEn, expAcc & reqWrite);
         checkOutput("RamAddr", ramAddr, reqAddr);
         checkOutput("RamBEn", ramBEn, reqBEn);
         checkOutput("RamWrData", ramWrData, reqWrData);
         checkOutput("RspValid", rspValid, expValid);
         checkOutput("Busy", busy, expQ.size() != 0);
         if (expValid) checkOutput("RspData", rspData, expQ[0].data);
         if (reset) begin
            expQ.delete();
         end else begin
            if (expValid && rspReady) void'(expQ.pop_front());
            if (expAcc) begin
               if (reqWrite) begin
                  for (int b = 0; b < 8; b++)
                     if (reqBEn[b]) refMem[reqAddr][8*b +: 8] = reqWrData[8*b +: 8];
               end else begin
                  newRsp.readyAt = cyc + RD_LAT + 1;
                  newRsp.data    = refMem[reqAddr];
                  expQ.push_back(newRsp);
               end
            end
         end
      end
      cyc++;
   end

   int          lat;
   int          accepted;
   int          stalls;
   int          respCount;
   int          stale;
   logic [63:0] data;

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initWord(i);
      repeat (2) @(posedge clock);
      #1;
      preload   = 1'b0;
      modelLive = 1'b1;
      reqValid  = 1'b1;
      reqWrite  = 1'b1;
      reqBEn    = 8'hFF;
      #1;
      checkOutput("reset RamCSel", ramCSel, 1'b0);
      checkOutput("reset RamWrEn", ramWrEn, 1'b0);
      checkOutput("reset RspValid", rspValid, 1'b0);
      checkOutput("reset Busy", busy, 1'b0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      reqValid = 1'b0;
      idleCycle(1'b1);

      $display("[TB] single read");
      applyStimulus(1'b1, 1'b0, 8'h00, 10'd5, 64'd0, 1'b1);
      #1 checkOutput("single read ready", reqReady, 1'b1);
      waitResponse(lat, data);
      checkOutput("single read latency", 64'(lat), 64'd3);
      checkOutput("single read data", data, 64'hDEADBEEF_CAFEF00D);

      $display("[TB] byte-enable write");
      applyStimulus(1'b1, 1'b1, 8'hFF, 10'd3, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'h0F, 10'd3, 64'h11223344_55667788, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 10'd3, 64'd0, 1'b1);
      waitResponse(lat, data);
      checkOutput("ben read latency", 64'(lat), 64'd3);
      checkOutput("ben read data", data, 64'hFFFFFFFF_55667788);

      $display("[TB] backpressure");
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 10'(20 + accepted), 64'd0, 1'b0);
         #1 if (reqReady) accepted++;
      end
      checkOutput("backpressure accepted", 64'(accepted), 64'd4);
      checkOutput("backpressure read stalled", reqReady, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'hFF, 10'd200, 64'hA5A5_5A5A_0123_4567, 1'b0);
      #1 checkOutput("backpressure write ready", reqReady, 1'b1);
      repeat (8) idleCycle(1'b1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 10'(24 + i), 64'd0, 1'b1);
         #1 checkOutput("post-drain read ready", reqReady, 1'b1);
      end
      repeat (8) idleCycle(1'b1);

      $display("[TB] streaming");
      stalls    = 0;
      respCount = 0;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 10'(i), 64'd0, 1'b1);
         #1;
         if (!reqReady) stalls++;
         if (rspValid) respCount++;
      end
      for (int i = 0; i < 8; i++) begin
         idleCycle(1'b1);
         #1 if (rspValid) respCount++;
      end
      checkOutput("stream stalls", 64'(stalls), 64'd0);
      checkOutput("stream responses", 64'(respCount), 64'd64);

      $display("[TB] accept and pop together");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 10'(40 + i), 64'd0, 1'b0);
      repeat (4) idleCycle(1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 10'd43, 64'd0, 1'b1);
      #1;
      checkOutput("accept+pop ready", reqReady, 1'b1);
      checkOutput("accept+pop valid", rspValid, 1'b1);
      accepted = 0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 10'(44 + i), 64'd0, 1'b0);
         #1 if (reqReady) accepted++;
      end
      checkOutput("credits after accept+pop", 64'(accepted), 64'd1);
      repeat (10) idleCycle(1'b1);

      $display("[TB] reset with reads in flight");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 10'(50 + i), 64'd0, 1'b1);
      idleCycle(1'b1);
      reset = 1'b1;
      idleCycle(1'b1);
      reset = 1'b0;
      #1;
      checkOutput("post-reset RspValid", rspValid, 1'b0);
      checkOutput("post-reset Busy", busy, 1'b0);
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         idleCycle(1'b1);
         #1 if (rspValid) stale++;
      end
      checkOutput("post-reset stale responses", 64'(stale), 64'd0);

      $display("[TB] random traffic");
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
                       10'($urandom_range(0, 15)), {$urandom, $urandom}, $urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 199) == 0);
      end
      idleCycle(1'b1);
      reset = 1'b0;
      repeat (20) idleCycle(1'b1);
      #1;
      checkOutput("final Busy", busy, 1'b0);
      checkOutput("final RspValid", rspValid, 1'b0);

      @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
